upconv_ddr_n: RTL and testbench

- Parametrised successor of the two-lane serialized-IQ-to-DDR upconverter.
- Takes one time-multiplexed I/Q stream (I on iq_flag high, Q on iq_flag low) and produces NLANE DAC words per clock, each lane with its own LO.
- Adds I/Q alignment tracking, a lock state machine, output gating with a valid flag, and saturation monitoring.
- Sits between the controller's serialized IQ output and the DDR DAC serializer.

---
 rtl/upconv_ddr_n.sv | 174 +++++++++++++++++
 tb/tb_upconv_ddr_n.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/upconv_ddr_n.sv
// Serialized I/Q to NLANE-lane DAC upconverter with I/Q alignment lock, gated outputs and saturation monitoring.
// Optional build macro UPCONV_SAT_MON_EN enables the saturation event counter (sat_count); without it sat_count is 0.
module upconv_ddr_n #(
    parameter int DW         = 18,
    parameter int LW         = 18,
    parameter int OW         = 16,
    parameter int NLANE      = 2,
    parameter int LOCK_PAIRS = 2,
    parameter int SCW        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] iq_data,
    input  logic                 iq_flag,
    input  logic [NLANE*LW-1:0]  lo,
    input  logic                 sat_clr,
    output logic [NLANE*OW-1:0]  dac,
    output logic                 dac_valid,
    output logic                 locked,
    output logic                 sync_err,
    output logic [SCW-1:0]       sat_count
);

    localparam int PW    = DW + LW;
    localparam int RUN_W = $clog2(2*LOCK_PAIRS + 1);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(2*LOCK_PAIRS);
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(2*LOCK_PAIRS - 1);
    localparam logic [2:0]       FILL_LAST = 3'd5;
    localparam logic signed [DW:0] SAT_POS = {2'b00, {(DW-1){1'b1}}};
    localparam logic signed [DW:0] SAT_NEG = -SAT_POS;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state;
    logic             prev_flag;
    logic [RUN_W-1:0] run_cnt;
    logic [2:0]       fill_cnt;
    logic             flag_rep;
    logic             dac_valid_next;
    logic [NLANE-1:0] clip_vec;

    // dac_valid qualifies dac: when high, every lane of dac carries locked, fully
    // filled pipeline data; when low, dac is forced to zero. There is no back-pressure.
    assign flag_rep       = (iq_flag == prev_flag);
    assign dac_valid_next = (state == LOCK) && !flag_rep && (fill_cnt == FILL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            prev_flag <= 1'b0;
            run_cnt   <= '0;
            fill_cnt  <= '0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
            dac_valid <= 1'b0;
        end else begin
            prev_flag <= iq_flag;
            sync_err  <= 1'b0;
            dac_valid <= dac_valid_next;
            case (state)
                HUNT: begin
                    fill_cnt <= '0;
                    if (flag_rep) begin
                        run_cnt <= '0;
                    end else begin
                        if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
                        // Lock only once the run is long enough and we sit on a Q sample.
                        if ((run_cnt >= RUN_LAST) && !iq_flag) begin
                            state   <= LOCK;
                            locked  <= 1'b1;
                            run_cnt <= '0;
                        end
                    end
                end
                LOCK: begin
                    if (flag_rep) begin
                        state    <= HUNT;
                        locked   <= 1'b0;
                        sync_err <= 1'b1;
                        fill_cnt <= '0;
                    end else if (fill_cnt != FILL_LAST) begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        logic signed [LW-1:0] lo_k;
        logic signed [PW-1:0] prod1;
        logic signed [DW-1:0] prod2;
        logic signed [DW-1:0] prod3;
        logic signed [DW:0]   sum;
        logic signed [DW-1:0] sum_sat;
        logic signed [DW-1:0] filt1;
        logic signed [DW-1:0] filt2;
        logic signed [DW:0]   interp;
        logic [OW-1:0]        cand;
        logic [OW-1:0]        dac_r;
        logic                 unused_lane;

        assign lo_k = lo[k*LW +: LW];
        assign sum  = {prod2[DW-1], prod2} + {prod3[DW-1], prod3};

        // Symmetric clip: the most negative code is also pulled in to -(2^(DW-1)-1).
        always_comb begin
            sum_sat = sum[DW-1:0];
            if (sum > SAT_POS) begin
                sum_sat = SAT_POS[DW-1:0];
            end else if (sum < SAT_NEG) begin
                sum_sat = SAT_NEG[DW-1:0];
            end
        end

        assign clip_vec[k] = iq_flag && ((sum > SAT_POS) || (sum < SAT_NEG));
        assign cand        = iq_flag ? ~interp[DW -: OW] : filt2[DW-1 -: OW];

        always_ff @(posedge clk) begin
            if (rst) begin
                prod1  <= '0;
                prod2  <= '0;
                prod3  <= '0;
                filt1  <= '0;
                filt2  <= '0;
                interp <= '0;
                dac_r  <= '0;
            end else begin
                prod1 <= PW'(lo_k) * PW'(iq_data);
                prod2 <= prod1[PW-2 -: DW];
                prod3 <= prod2;
                if (iq_flag) begin
                    filt1 <= sum_sat;
                    filt2 <= filt1;
                end else begin
                    interp <= {filt1[DW-1], filt1} + {filt2[DW-1], filt2} - (DW+1)'(1);
                end
                dac_r <= dac_valid_next ? cand : '0;
            end
        end

        assign dac[k*OW +: OW] = dac_r;
        assign unused_lane = &{1'b0, prod1[PW-1], prod1[LW-2:0], interp[DW-OW:0], filt2[DW-OW-1:0]};
    end

`ifdef UPCONV_SAT_MON_EN
    logic [SCW-1:0] sat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if ((|clip_vec) && (sat_cnt != {SCW{1'b1}})) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

    assign sat_count = sat_cnt;
`else
    logic unused_sat;

    assign sat_count  = '0;
    assign unused_sat = &{1'b0, sat_clr, clip_vec};
`endif

endmodule

// File: tb/tb_upconv_ddr_n.sv
// Bench for upconv_ddr_n: directed tone table, multi-cycle lock/glitch/reset/clear sequences, and random traffic vs. a reference model.
module tb_upconv_ddr_n;

    localparam int DW         = 18;
    localparam int LW         = 18;
    localparam int OW         = 16;
    localparam int NLANE      = 2;
    localparam int LOCK_PAIRS = 2;
    localparam int SCW        = 8;
    localparam longint SMAX    = (longint'(1) << (DW-1)) - 1;
    localparam longint SAT_TOP = (longint'(1) << SCW) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] iq_data;
    logic                 iq_flag;
    logic [NLANE*LW-1:0]  lo;
    logic                 sat_clr;
    logic [NLANE*OW-1:0]  dac;
    logic                 dac_valid;
    logic                 locked;
    logic                 sync_err;
    logic [SCW-1:0]       sat_count;

    always #5 clk = ~clk;

    upconv_ddr_n #(
        .DW(DW), .LW(LW), .OW(OW), .NLANE(NLANE), .LOCK_PAIRS(LOCK_PAIRS), .SCW(SCW)
    ) dut (
        .clk(clk), .rst(rst), .iq_data(iq_data), .iq_flag(iq_flag), .lo(lo),
        .sat_clr(sat_clr), .dac(dac), .dac_valid(dac_valid), .locked(locked),
        .sync_err(sync_err), .sat_count(sat_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: integer pipeline values and plain lock bookkeeping.
    longint m_p1[NLANE], m_p2[NLANE], m_p3[NLANE];
    longint m_f1[NLANE], m_f2[NLANE], m_ip[NLANE], m_dac[NLANE];
    int     m_run, m_lock_len;
    longint m_satc;
    bit     m_lk, m_prev, m_serr, m_dv;

    typedef struct {
        int lo0;
        int lo1;
        int iq;
        int exp0_lo;
        int exp0_hi;
        int exp1_lo;
        int exp1_hi;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit     rep;
        bit     clip_any;
        longint sum, sat_v, cand, lo_k;
        clip_any = 1'b0;
        if (rst) begin
            for (int k = 0; k < NLANE; k++) begin
                m_p1[k] = 0; m_p2[k] = 0; m_p3[k] = 0;
                m_f1[k] = 0; m_f2[k] = 0; m_ip[k] = 0; m_dac[k] = 0;
            end
            m_run = 0; m_lock_len = 0; m_satc = 0;
            m_lk = 0; m_prev = 0; m_serr = 0; m_dv = 0;
            return;
        end
        rep = (iq_flag == m_prev);
        m_serr = 0;
        if (m_lk) begin
            if (rep) begin
                m_lk = 0; m_serr = 1; m_run = 0; m_lock_len = 0;
            end else if (m_lock_len < 100) begin
                m_lock_len++;
            end
        end else begin
            m_run = rep ? 0 : m_run + 1;
            if (m_run >= 2*LOCK_PAIRS && !iq_flag) begin
                m_lk = 1; m_lock_len = 1; m_run = 0;
            end
        end
        // Valid once the lock has held for six further edges.
        m_dv = m_lk && (m_lock_len >= 7);
        for (int k = 0; k < NLANE; k++) begin
            lo_k  = longint'($signed(lo[k*LW +: LW]));
            sum   = m_p2[k] + m_p3[k];
            sat_v = (sum > SMAX) ? SMAX : ((sum < -SMAX) ? -SMAX : sum);
            if (iq_flag && (sat_v != sum)) clip_any = 1'b1;
            cand  = iq_flag ? (-(m_ip[k] >>> (DW+1-OW)) - 1) : (m_f2[k] >>> (DW-OW));
            m_dac[k] = m_dv ? cand : 0;
            if (iq_flag) begin
                m_f2[k] = m_f1[k];
                m_f1[k] = sat_v;
            end else begin
                m_ip[k] = m_f1[k] + m_f2[k] - 1;
            end
            m_p3[k] = m_p2[k];
            m_p2[k] = m_p1[k] >>> (LW-1);
            m_p1[k] = lo_k * longint'(iq_data);
        end
`ifdef UPCONV_SAT_MON_EN
        if (sat_clr) m_satc = 0;
        else if (clip_any && m_satc < SAT_TOP) m_satc++;
`else
        m_satc = 0;
`endif
        m_prev = iq_flag;
    endtask

    task automatic compare_all();
        for (int k = 0; k < NLANE; k++)
            chk($sformatf("model_dac%0d", k), longint'($signed(dac[k*OW +: OW])), m_dac[k]);
        chk("model_dac_valid", longint'(dac_valid), longint'(m_dv));
        chk("model_locked", longint'(locked), longint'(m_lk));
        chk("model_sync_err", longint'(sync_err), longint'(m_serr));
        chk("model_sat_count", longint'(sat_count), m_satc);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic alt_step();
        iq_flag = ~iq_flag;
        step();
    endtask

    task automatic set_lo(input int l0, input int l1);
        lo = {LW'(l1), LW'(l0)};
    endtask

    function automatic int rand_lo();
        return int'($urandom_range(0, 262142)) - 131071;
    endfunction

    task automatic relock_and_fill(input string tag);
        int waited;
        waited = 0;
        while (!locked && waited < 12) begin
            alt_step();
            waited++;
        end
        chk({tag, "_relock"}, longint'(locked), 1);
        for (int i = 1; i <= 6; i++) begin
            alt_step();
            chk({tag, "_fill"}, longint'(dac_valid), (i == 6) ? 1 : 0);
        end
    endtask

    initial begin
        vecs[0] = '{lo0: 0,       lo1: 0,      iq: 0,       exp0_lo: 0,      exp0_hi: 0,      exp1_lo: 0,     exp1_hi: 0};
        vecs[1] = '{lo0: 65536,   lo1: 0,      iq: 65536,   exp0_lo: 16384,  exp0_hi: -16384, exp1_lo: 0,     exp1_hi: 0};
        vecs[2] = '{lo0: 131071,  lo1: 0,      iq: 131071,  exp0_lo: 32767,  exp0_hi: -32768, exp1_lo: 0,     exp1_hi: 0};
        vecs[3] = '{lo0: -131071, lo1: 65536,  iq: 131071,  exp0_lo: -32768, exp0_hi: 32767,  exp1_lo: 32767, exp1_hi: -32768};
        vecs[4] = '{lo0: 65536,   lo1: -65536, iq: -65536,  exp0_lo: -16384, exp0_hi: 16384,  exp1_lo: 16384, exp1_hi: -16384};

        rst = 1'b1; iq_flag = 1'b0; iq_data = '0; lo = '0; sat_clr = 1'b0;
        repeat (4) step();
        chk("reset_dac", longint'(dac), 0);
        chk("reset_valid", longint'(dac_valid), 0);
        chk("reset_locked", longint'(locked), 0);
        chk("reset_sync_err", longint'(sync_err), 0);
        chk("reset_sat_count", longint'(sat_count), 0);
        rst = 1'b0;

        // Zero input: lock on the 4th alternation (a Q sample), valid 6 edges later.
        for (int i = 1; i <= 4; i++) begin
            alt_step();
            chk("zero_lock_seq", longint'(locked), (i == 4) ? 1 : 0);
        end
        for (int i = 1; i <= 6; i++) begin
            alt_step();
            chk("zero_fill_seq", longint'(dac_valid), (i == 6) ? 1 : 0);
            chk("zero_dac", longint'(dac), 0);
        end

        // Steady-state tone table.
        for (int v = 0; v < 5; v++) begin
            set_lo(vecs[v].lo0, vecs[v].lo1);
            iq_data = DW'(vecs[v].iq);
            repeat (16) alt_step();
            if (iq_flag == 1'b0) alt_step();
            alt_step();
            chk($sformatf("vec%0d_lane0_q", v), longint'($signed(dac[0 +: OW])), vecs[v].exp0_lo);
            chk($sformatf("vec%0d_lane1_q", v), longint'($signed(dac[OW +: OW])), vecs[v].exp1_lo);
            alt_step();
            chk($sformatf("vec%0d_lane0_i", v), longint'($signed(dac[0 +: OW])), vecs[v].exp0_hi);
            chk($sformatf("vec%0d_lane1_i", v), longint'($signed(dac[OW +: OW])), vecs[v].exp1_hi);
        end

        // Long saturation run: counter must stick at all-ones.
        set_lo(131071, 0);
        iq_data = DW'(131071);
        repeat (600) alt_step();
`ifdef UPCONV_SAT_MON_EN
        chk("sat_hold", longint'(sat_count), SAT_TOP);
`else
        chk("sat_hold", longint'(sat_count), 0);
`endif

        // Clear on a saturating I cycle wins over the increment.
        if (iq_flag == 1'b1) alt_step();
        sat_clr = 1'b1;
        alt_step();
        chk("sat_clr_prio", longint'(sat_count), 0);
        sat_clr = 1'b0;
        alt_step();
        alt_step();
`ifdef UPCONV_SAT_MON_EN
        chk("sat_after_clr", longint'(sat_count), 1);
`else
        chk("sat_after_clr", longint'(sat_count), 0);
`endif

        // Glitch: repeated flag while locked.
        set_lo(65536, 0);
        iq_data = DW'(65536);
        repeat (12) alt_step();
        step();
        chk("glitch_sync_err", longint'(sync_err), 1);
        chk("glitch_locked", longint'(locked), 0);
        chk("glitch_valid", longint'(dac_valid), 0);
        chk("glitch_dac", longint'(dac), 0);
        alt_step();
        chk("glitch_pulse_end", longint'(sync_err), 0);
        relock_and_fill("glitch");
        repeat (6) alt_step();

        // Reset while locked and outputting the DC tone.
        rst = 1'b1;
        alt_step();
        rst = 1'b0;
        chk("midrst_dac", longint'(dac), 0);
        chk("midrst_valid", longint'(dac_valid), 0);
        chk("midrst_locked", longint'(locked), 0);
        chk("midrst_sat_count", longint'(sat_count), 0);
        relock_and_fill("midrst");

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) set_lo(rand_lo(), rand_lo());
            iq_data = DW'($urandom_range(0, (1 << DW) - 1));
            if ($urandom_range(0, 39) != 0) iq_flag = ~iq_flag;
            sat_clr = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        sat_clr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
